// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the SDRAM Wishbone arbiter.
package wb_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN_LCD, OWN_PROC, GAP} arb_state_e;
    typedef logic [1:0] grant_t;
    localparam grant_t GRANT_NONE = 2'b00;
    localparam grant_t GRANT_LCD  = 2'b10;
    localparam grant_t GRANT_PROC = 2'b01;
    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
endpackage

// File: rtl/wishbone_b3.sv
// wishbone_b3: classic Wishbone B3 bus bundle with master and slave views.
interface wishbone_b3;
    import wb_arb_pkg::*;
    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W/8-1:0] sel;
    logic [DAT_W-1:0] dat_m2s;
    logic [DAT_W-1:0] dat_s2m;
    logic [2:0]       cti;
    logic             ack;
    logic             err;
    modport master(output cyc, stb, we, adr, sel, dat_m2s, cti, input ack, err, dat_s2m);
    modport slave(input cyc, stb, we, adr, sel, dat_m2s, cti, output ack, err, dat_s2m);
endinterface

// File: rtl/arb_watchdog.sv
// arb_watchdog: counts consecutive unanswered strobe cycles and flags the last allowed one.
module arb_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic hit
);
    localparam int W = $clog2(TIMEOUT);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clr ? '0 : run ? cnt_q + 1'b1 : cnt_q;
        hit   = run && cnt_q == W'(TIMEOUT - 1);
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/wb_sdram_arbiter.sv
// wb_sdram_arbiter: shares the SDRAM Wishbone port between LCD DMA (priority) and
// the processor, bounding each tenure by an ack quota and erroring out hung transfers.
module wb_sdram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int LCD_QUOTA  = 16,
    parameter int PROC_QUOTA = 4,
    parameter int TIMEOUT    = 1024,
    parameter int TMO_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    wishbone_b3.slave        lcd,
    wishbone_b3.slave        proc,
    wishbone_b3.master       mem,
    output grant_t           grant,
    output logic [TMO_W-1:0] timeout_count
);
    localparam int QMAX = LCD_QUOTA > PROC_QUOTA ? LCD_QUOTA : PROC_QUOTA;
    localparam int QW   = $clog2(QMAX + 1);

    arb_state_e       state_q, state_d;
    logic             last_lcd_q, last_lcd_d;
    logic [QW-1:0]    quota_q, quota_d, limit;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic own, is_lcd, lcd_req, proc_req, other_req, o_cyc, o_stb;
    logic stall, stb_int, wd_hit, expire, wd_clr;

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk(clk),
        .rst(rst),
        .run(stb_int),
        .clr(wd_clr),
        .hit(wd_hit)
    );

    always_comb begin
        state_d    = state_q;
        last_lcd_d = last_lcd_q;
        quota_d    = quota_q;
        tmo_d      = tmo_q;
        own        = state_q == OWN_LCD || state_q == OWN_PROC;
        is_lcd     = state_q == OWN_LCD;
        lcd_req    = lcd.cyc && lcd.stb;
        proc_req   = proc.cyc && proc.stb;
        o_cyc      = is_lcd ? lcd.cyc : proc.cyc;
        o_stb      = is_lcd ? lcd.stb : proc.stb;
        other_req  = is_lcd ? proc_req : lcd_req;
        limit      = is_lcd ? QW'(LCD_QUOTA) : QW'(PROC_QUOTA);
        // Owner that used up its quota is stalled while the other master waits.
        stall      = quota_q == limit && other_req;
        stb_int    = own && o_cyc && o_stb && !stall;
        wd_clr     = !stb_int || mem.ack || mem.err;
        expire     = wd_hit && !mem.ack && !mem.err;
        mem.cyc     = own && o_cyc && !expire;
        mem.stb     = stb_int && !expire;
        mem.we      = is_lcd ? lcd.we : proc.we;
        mem.adr     = is_lcd ? lcd.adr : proc.adr;
        mem.sel     = is_lcd ? lcd.sel : proc.sel;
        mem.dat_m2s = is_lcd ? lcd.dat_m2s : proc.dat_m2s;
        mem.cti     = is_lcd ? lcd.cti : proc.cti;
        lcd.ack      = is_lcd && mem.ack;
        lcd.err      = is_lcd && (mem.err || expire);
        lcd.dat_s2m  = mem.dat_s2m;
        proc.ack     = state_q == OWN_PROC && mem.ack;
        proc.err     = state_q == OWN_PROC && (mem.err || expire);
        proc.dat_s2m = mem.dat_s2m;
        if (own) begin
            if (mem.ack && quota_q != limit) quota_d = quota_q + 1'b1;
            if (!o_cyc || stall || expire) begin
                state_d    = GAP;
                quota_d    = '0;
                last_lcd_d = is_lcd;
            end
        end else if (state_q == GAP) begin
            state_d = (last_lcd_q ? proc_req : lcd_req) ? (last_lcd_q ? OWN_PROC : OWN_LCD) :
                      (last_lcd_q ? lcd.cyc : proc.cyc) ? (last_lcd_q ? OWN_LCD : OWN_PROC) : IDLE;
        end else begin
            state_d = lcd_req ? OWN_LCD : proc_req ? OWN_PROC : IDLE;
        end
        if (expire && tmo_q != '1) tmo_d = tmo_q + 1'b1;
        grant         = is_lcd ? GRANT_LCD : state_q == OWN_PROC ? GRANT_PROC : GRANT_NONE;
        timeout_count = tmo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_lcd_q <= 1'b0;
            quota_q    <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_lcd_q <= last_lcd_d;
            quota_q    <= quota_d;
            tmo_q      <= tmo_d;
        end
    end
endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// tb_wb_sdram_arbiter: directed vectors and sequences for the SDRAM port arbiter.
module tb_wb_sdram_arbiter;
    import wb_arb_pkg::*;

    localparam logic [31:0] L_BASE = 32'h1000_0000;
    localparam logic [31:0] P_BASE = 32'h2000_0000;
    localparam logic [31:0] K      = 32'h5A5A_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    grant_t grant;
    logic [7:0] tmo;

    wishbone_b3 lcd_if();
    wishbone_b3 proc_if();
    wishbone_b3 mem_if();

    wb_sdram_arbiter #(.LCD_QUOTA(16), .PROC_QUOTA(4), .TIMEOUT(32), .TMO_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .lcd(lcd_if),
        .proc(proc_if),
        .mem(mem_if),
        .grant(grant),
        .timeout_count(tmo)
    );

    always #5 clk = ~clk;

    // Classic-handshake slave: acks 'lat' cycles after first seeing a strobe.
    logic s_en = 1'b0;
    logic s_ack = 1'b0;
    logic [31:0] s_dat = '0;
    int lat = 0;
    int w = 0;
    always @(posedge clk) begin
        if (rst) begin
            s_ack <= 1'b0;
            w <= 0;
        end else if (s_en && mem_if.cyc && mem_if.stb && !s_ack) begin
            if (w == lat) begin
                s_ack <= 1'b1;
                s_dat <= mem_if.adr ^ K;
                w <= 0;
            end else w <= w + 1;
        end else begin
            s_ack <= 1'b0;
            w <= 0;
        end
    end
    assign mem_if.ack = s_ack;
    assign mem_if.err = 1'b0;
    assign mem_if.dat_s2m = s_dat;

    logic l_on, l_stb, p_on, p_stb;
    int l_len, p_len, l_acks, p_acks, l_errs, p_errs, p_at, p_first_l;
    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] g_val[$];
    int g_len[$];

    typedef struct {
        logic lc, ls, pc, ps;
        logic [1:0] g;
        logic mc;
        logic chk_adr;
        logic [31:0] adr;
    } vec_t;
    vec_t v[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive();
        lcd_if.cyc = l_on && (l_acks < l_len);
        lcd_if.stb = lcd_if.cyc && l_stb;
        lcd_if.adr = L_BASE + 32'(l_acks * 4);
        lcd_if.we = 1'b0;
        lcd_if.sel = 4'hF;
        lcd_if.dat_m2s = 32'(l_acks);
        lcd_if.cti = 3'b010;
        proc_if.cyc = p_on && (p_acks < p_len);
        proc_if.stb = proc_if.cyc && p_stb;
        proc_if.adr = P_BASE + 32'(p_acks * 4);
        proc_if.we = 1'b0;
        proc_if.sel = 4'hF;
        proc_if.dat_m2s = 32'(p_acks);
        proc_if.cti = 3'b000;
    endtask

    task automatic step();
        @(negedge clk);
        if (g_val.size() == 0 || g_val[$] != grant) begin
            g_val.push_back(grant);
            g_len.push_back(1);
        end else g_len[$] = g_len[$] + 1;
        if (lcd_if.ack) begin
            chk("lcd_dat", lcd_if.dat_s2m, (L_BASE + 32'(l_acks * 4)) ^ K);
            l_acks++;
        end
        if (lcd_if.err) l_errs++;
        if (proc_if.ack) begin
            if (p_acks == 0) p_first_l = l_acks;
            chk("proc_dat", proc_if.dat_s2m, (P_BASE + 32'(p_acks * 4)) ^ K);
            p_acks++;
        end
        if (proc_if.err) p_errs++;
        if (p_at >= 0 && l_acks == p_at) begin
            p_on = 1'b1;
            p_at = -1;
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        l_on = 0; p_on = 0; l_stb = 1; p_stb = 1;
        l_len = 0; p_len = 0; l_acks = 0; p_acks = 0; l_errs = 0; p_errs = 0;
        p_at = -1; p_first_l = -1; s_en = 0; lat = 0;
        drive();
        step();
        step();
        rst = 1'b0;
        g_val.delete();
        g_len.delete();
    endtask

    task automatic run(input string name, input int max);
        logic done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            step();
            done = !lcd_if.cyc && !proc_if.cyc && grant == GRANT_NONE;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        logic [11:0] seq;
        logic [7:0] seq4;
        logic hit;
        // reset held with both masters requesting
        l_on = 1; p_on = 1; l_stb = 1; p_stb = 1; l_len = 100; p_len = 100;
        l_acks = 0; p_acks = 0; l_errs = 0; p_errs = 0; p_at = -1; p_first_l = -1;
        s_en = 1;
        drive();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_cyc", 32'(mem_if.cyc), 32'h0);
        end
        chk("rst_tmo", 32'(tmo), 32'h0);
        rst = 1'b0;
        step();
        chk("rel_grant", 32'(grant), 32'(GRANT_LCD));

        // single-cycle arbitration from IDLE
        v[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0};
        v[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, L_BASE};
        v[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, P_BASE};
        v[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1, L_BASE};
        v[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, P_BASE};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            l_on = v[i].lc; l_stb = v[i].ls; p_on = v[i].pc; p_stb = v[i].ps;
            l_len = 1; p_len = 1;
            drive();
            step();
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(v[i].g));
            chk($sformatf("vec%0d_cyc", i), 32'(mem_if.cyc), 32'(v[i].mc));
            chk($sformatf("vec%0d_stb", i), 32'(mem_if.stb), 32'(v[i].mc));
            if (v[i].chk_adr) chk($sformatf("vec%0d_adr", i), mem_if.adr, v[i].adr);
        end

        // processor alone, single read, slow slave
        do_reset();
        s_en = 1; lat = 5; p_on = 1; p_len = 1;
        drive();
        step();
        chk("p1_grant", 32'(grant), 32'(GRANT_PROC));
        chk("p1_cyc", 32'(mem_if.cyc), 32'h1);
        for (int i = 0; i < 20 && p_acks == 0; i++) step();
        chk("p1_acks", 32'(p_acks), 32'd1);
        step();
        chk("p1_gap_cyc", 32'(mem_if.cyc), 32'h0);
        chk("p1_gap_grant", 32'(grant), 32'h0);
        step();
        step();
        chk("p1_idle_grant", 32'(grant), 32'h0);
        chk("p1_no_dup", 32'(p_acks), 32'd1);

        // LCD 64-beat burst, processor joins at beat 3
        do_reset();
        s_en = 1; lat = 0; l_on = 1; l_len = 64; p_len = 4; p_at = 3;
        drive();
        run("t4_done", 1000);
        chk("t4_lcd_acks", 32'(l_acks), 32'd64);
        chk("t4_proc_acks", 32'(p_acks), 32'd4);
        chk("t4_quota", 32'(p_first_l), 32'd16);
        chk("t4_runs", 32'(g_val.size()), 32'd6);
        seq = '0;
        if (g_val.size() >= 6) seq = {g_val[0], g_val[1], g_val[2], g_val[3], g_val[4], g_val[5]};
        chk("t4_seq", 32'(seq), 32'h0000_0848);
        chk("t4_gap1", 32'(g_len.size() > 3 ? g_len[1] : 0), 32'd1);
        chk("t4_gap2", 32'(g_len.size() > 3 ? g_len[3] : 0), 32'd1);

        // simultaneous request, LCD finishes before its quota
        do_reset();
        s_en = 1; lat = 0; l_on = 1; l_len = 5; p_on = 1; p_len = 3;
        drive();
        run("t5_done", 200);
        chk("t5_first", 32'(p_first_l), 32'd5);
        chk("t5_proc_acks", 32'(p_acks), 32'd3);
        seq4 = '0;
        if (g_val.size() >= 4) seq4 = {g_val[0], g_val[1], g_val[2], g_val[3]};
        chk("t5_seq", 32'(seq4), 32'h0000_0084);

        // ack arriving on the watchdog's last cycle wins
        do_reset();
        s_en = 1; lat = 30; p_on = 1; p_len = 2;
        drive();
        for (int i = 0; i < 31; i++) step();
        chk("race_pre", 32'(p_acks), 32'd0);
        step();
        chk("race_ack", 32'(proc_if.ack), 32'h1);
        chk("race_err", 32'(proc_if.err), 32'h0);
        step();
        chk("race_tmo", 32'(tmo), 32'h0);
        chk("race_grant", 32'(grant), 32'(GRANT_PROC));

        // watchdog expiry and saturation
        do_reset();
        p_on = 1; p_len = 1;
        drive();
        step();
        chk("wd_grant", 32'(grant), 32'(GRANT_PROC));
        l_on = 1; l_len = 1;
        drive();
        for (int i = 0; i < 30; i++) step();
        chk("wd_early", 32'(proc_if.err), 32'h0);
        step();
        chk("wd_err", 32'(proc_if.err), 32'h1);
        chk("wd_cyc", 32'(mem_if.cyc), 32'h0);
        chk("wd_tmo0", 32'(tmo), 32'h0);
        step();
        chk("wd_gap", 32'(grant), 32'h0);
        chk("wd_tmo1", 32'(tmo), 32'h1);
        chk("wd_perr", 32'(p_errs), 32'd1);
        step();
        chk("wd_regrant", 32'(grant), 32'(GRANT_LCD));
        for (int i = 0; i < 32; i++) step();
        chk("wd_tmo2", 32'(tmo), 32'h2);
        chk("wd_lerr", 32'(l_errs), 32'd1);
        hit = 1'b0;
        for (int i = 0; i < 10000 && !hit; i++) begin
            step();
            hit = tmo == 8'hFF;
        end
        chk("wd_sat", 32'(tmo), 32'hFF);
        for (int i = 0; i < 70; i++) step();
        chk("wd_hold", 32'(tmo), 32'hFF);

        // reset in the middle of an LCD burst
        do_reset();
        s_en = 1; lat = 0; l_on = 1; l_len = 64;
        drive();
        for (int i = 0; i < 100 && l_acks < 7; i++) step();
        chk("mr_beats", 32'(l_acks), 32'd7);
        rst = 1'b1;
        step();
        chk("mr_cyc", 32'(mem_if.cyc), 32'h0);
        chk("mr_grant", 32'(grant), 32'h0);
        chk("mr_ack", 32'(lcd_if.ack), 32'h0);
        step();
        step();
        chk("mr_no_more", 32'(l_acks), 32'd7);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
